input_debouncer: RTL and testbench

Conditioning stage that sits directly upstream of the `d_flip_flop` data input. It takes an asynchronous, bouncy 1-bit input (button or switch) and synchronises it into `clk` with a 2-flop synchroniser. It then debounces it with a stability counter and presents a clean level plus single-cycle rise/fall strobes. Downstream registers capture `level` or the strobes directly.

---
 rtl/input_debouncer_if.sv | 12 +
 rtl/input_debouncer.sv | 93 +++++++++
 tb/tb_input_debouncer.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/input_debouncer_if.sv
// Signal bundle between a bouncy raw input source and the debouncer.
// The master drives the raw input; the slave returns the conditioned level and strobes.
interface input_debouncer_if;
  logic din;
  logic level;
  logic rise;
  logic fall;
  logic busy;

  modport master (output din, input level, rise, fall, busy);
  modport slave  (input din, output level, rise, fall, busy);
endinterface

// File: rtl/input_debouncer.sv
// Two-flop synchroniser followed by a stability-counter debouncer.
// Emits a registered clean level plus single-cycle rise/fall strobes.
//
// state    | meaning
// IDLE     | s2 agrees with level, counter held at zero
// SETTLING | s2 differs from level, counting consecutive disagreeing samples
module input_debouncer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 16,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  input_debouncer_if.slave  dbi
);

  typedef enum logic {IDLE, SETTLING} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  state_t               state;
  logic                 s1;
  logic                 s2;
  logic                 level_q;
  logic                 rise_q;
  logic                 fall_q;
  logic                 busy_q;
  logic [CNT_WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RESET_LEVEL;
      s2 <= RESET_LEVEL;
    end else begin
      s1 <= dbi.din;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (s2 != level_q) begin
            // A single-sample requirement flips immediately and never enters SETTLING.
            if (STABLE_CYCLES == 1) begin
              level_q <= ~level_q;
              rise_q  <= ~level_q;
              fall_q  <= level_q;
            end else begin
              state  <= SETTLING;
              cnt    <= CNT_ONE;
              busy_q <= 1'b1;
            end
          end
        end
        SETTLING: begin
          if (s2 == level_q) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            level_q <= ~level_q;
            rise_q  <= ~level_q;
            fall_q  <= level_q;
            state   <= IDLE;
            cnt     <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

  assign dbi.level = level_q;
  assign dbi.rise  = rise_q;
  assign dbi.fall  = fall_q;
  assign dbi.busy  = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed checks of the debouncer: default instance plus a STABLE_CYCLES=1 instance.
// Inputs change 1 ns after a rising edge; outputs are sampled at the same point.
module tb_input_debouncer;
  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  input_debouncer_if bus_a ();
  input_debouncer_if bus_b ();

  input_debouncer u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dbi   (bus_a)
  );

  input_debouncer #(.STABLE_CYCLES(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .dbi   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus_a.din = 1'b1;
    bus_b.din = 1'b0;

    // reset held with din high
    #2;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_level", bus_a.level, 1'b0);
      chk("rst_rise",  bus_a.rise,  1'b0);
      chk("rst_fall",  bus_a.fall,  1'b0);
      chk("rst_busy",  bus_a.busy,  1'b0);
    end
    rst_n = 1'b1;
    #1;
    chk("rel_level", bus_a.level, 1'b0);
    chk("rel_rise",  bus_a.rise,  1'b0);
    chk("rel_busy",  bus_a.busy,  1'b0);
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("rel_wait_level", bus_a.level, 1'b0);
      chk("rel_wait_rise",  bus_a.rise,  1'b0);
      if (e == 3) chk("rel_busy_e3", bus_a.busy, 1'b1);
    end
    step();
    chk("rel_e6_rise",  bus_a.rise,  1'b1);
    chk("rel_e6_level", bus_a.level, 1'b1);
    chk("rel_e6_busy",  bus_a.busy,  1'b0);
    step();
    chk("rel_e7_rise",  bus_a.rise,  1'b0);
    chk("rel_e7_level", bus_a.level, 1'b1);

    // clean falling step
    bus_a.din = 1'b0;
    repeat (5) begin
      step();
      chk("fall_wait_fall",  bus_a.fall,  1'b0);
      chk("fall_wait_level", bus_a.level, 1'b1);
    end
    step();
    chk("fall_e6_fall",  bus_a.fall,  1'b1);
    chk("fall_e6_level", bus_a.level, 1'b0);
    chk("fall_e6_rise",  bus_a.rise,  1'b0);
    step();
    chk("fall_e7_fall",  bus_a.fall,  1'b0);

    // 3-cycle glitch is rejected
    bus_a.din = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      if (e == 3) begin
        bus_a.din = 1'b0;
        chk("glitch_busy_e3", bus_a.busy, 1'b1);
      end
      chk("glitch_level", bus_a.level, 1'b0);
      chk("glitch_rise",  bus_a.rise,  1'b0);
    end
    chk("glitch_busy_end", bus_a.busy, 1'b0);

    // 4-cycle pulse passes, then falls back
    bus_a.din = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step();
      if (e == 4) bus_a.din = 1'b0;
      chk("pulse4_wait_rise", bus_a.rise, 1'b0);
    end
    step();
    chk("pulse4_e6_rise",  bus_a.rise,  1'b1);
    chk("pulse4_e6_level", bus_a.level, 1'b1);
    for (int e = 7; e <= 9; e++) begin
      step();
      chk("pulse4_wait_fall", bus_a.fall, 1'b0);
      chk("pulse4_hold_rise", bus_a.rise, 1'b0);
    end
    step();
    chk("pulse4_e10_fall",  bus_a.fall,  1'b1);
    chk("pulse4_e10_level", bus_a.level, 1'b0);

    // bounce 1,0,1,0,1 then hold 1: one rise, 6 edges after final 0->1 sample
    bus_a.din = 1'b1; step(); chk("bounce_rise_e1", bus_a.rise, 1'b0);
    bus_a.din = 1'b0; step(); chk("bounce_rise_e2", bus_a.rise, 1'b0);
    bus_a.din = 1'b1; step(); chk("bounce_rise_e3", bus_a.rise, 1'b0);
    bus_a.din = 1'b0; step(); chk("bounce_rise_e4", bus_a.rise, 1'b0);
    bus_a.din = 1'b1; step(); chk("bounce_rise_e5", bus_a.rise, 1'b0);
    for (int e = 6; e <= 9; e++) begin
      step();
      chk("bounce_wait_rise",  bus_a.rise,  1'b0);
      chk("bounce_wait_level", bus_a.level, 1'b0);
    end
    step();
    chk("bounce_e10_rise",  bus_a.rise,  1'b1);
    chk("bounce_e10_level", bus_a.level, 1'b1);
    step();
    chk("bounce_e11_rise",  bus_a.rise,  1'b0);
    bus_a.din = 1'b0;
    repeat (6) step();
    chk("bounce_ret_fall",  bus_a.fall,  1'b1);
    chk("bounce_ret_level", bus_a.level, 1'b0);

    // async reset while SETTLING with cnt == 2
    bus_a.din = 1'b1;
    repeat (4) step();
    chk("mid_busy_pre", bus_a.busy, 1'b1);
    chk("mid_cnt_pre",  u_dut.cnt == 16'd2, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_busy_clr",  bus_a.busy,  1'b0);
    chk("mid_cnt_clr",   u_dut.cnt == 16'd0, 1'b1);
    chk("mid_level",     bus_a.level, 1'b0);
    chk("mid_rise",      bus_a.rise,  1'b0);
    bus_a.din = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      chk("mid_post_level", bus_a.level, 1'b0);
      chk("mid_post_rise",  bus_a.rise,  1'b0);
      chk("mid_post_busy",  bus_a.busy,  1'b0);
    end

    // STABLE_CYCLES = 1: flip at edge 3, single-cycle glitch passes
    bus_b.din = 1'b1;
    step(); chk("s1_e1_level", bus_b.level, 1'b0);
    step(); chk("s1_e2_level", bus_b.level, 1'b0);
    step();
    chk("s1_e3_rise",  bus_b.rise,  1'b1);
    chk("s1_e3_level", bus_b.level, 1'b1);
    chk("s1_e3_busy",  bus_b.busy,  1'b0);
    step();
    chk("s1_e4_rise",  bus_b.rise,  1'b0);
    chk("s1_e4_level", bus_b.level, 1'b1);
    bus_b.din = 1'b0;
    step();
    bus_b.din = 1'b1;
    step(); chk("s1g_e2_level", bus_b.level, 1'b1);
    step();
    chk("s1g_e3_fall",  bus_b.fall,  1'b1);
    chk("s1g_e3_level", bus_b.level, 1'b0);
    step();
    chk("s1g_e4_rise",  bus_b.rise,  1'b1);
    chk("s1g_e4_fall",  bus_b.fall,  1'b0);
    chk("s1g_e4_level", bus_b.level, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
